// File: rtl/dmem_arb_pkg.sv
// Shared FSM state, counter width and address-decode constants for dmem_arbiter.
// Build option DMEM_ARB_RR_EN (consumed by dmem_rr_arb) selects round-robin arbitration.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Wide enough for MEM_LAT up to 7.
  localparam int LAT_CNT_W = 3;

  // Word index into the 256-entry data memory.
  localparam int WIDX_HI = 9;
  localparam int WIDX_LO = 2;
  localparam int WIDX_W  = WIDX_HI - WIDX_LO + 1;

  // Any address bit at or above RANGE_LSB, or any misaligned low bit, faults.
  localparam int         RANGE_LSB  = 10;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-port grant logic; fixed priority (port 0) by default, round-robin with DMEM_ARB_RR_EN.
// The round-robin pointer moves once per completed access, when update is pulsed.
import dmem_arb_pkg::*;

module dmem_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic [1:0] grant
);

`ifdef DMEM_ARB_RR_EN
  // Port that wins the next tie: the one not granted most recently.
  logic prio;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (update) begin
      prio <= ~served;
    end
  end

  always_comb begin
    grant = req;
    if (&req) begin
      grant = prio ? 2'b10 : 2'b01;
    end
  end
`else
  logic unused_rr_inputs;
  assign unused_rr_inputs = ^{clk, rst, update, served};

  always_comb begin
    grant = req;
    if (req[0]) begin
      grant = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE -> ISSUE -> (WAIT) -> RESP, one access at a time.
// Arbitration mode set by DMEM_ARB_RR_EN (round-robin) vs default fixed priority to port 0.
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  output logic              stall0,

  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic              stall1,

  output logic              mem_read,
  output logic              mem_write,
  output logic [WIDX_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t           state;
  arb_state_t           state_nxt;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic                 win_id;
  logic                 lat_we;
  logic [ADDR_W-1:0]    lat_addr;
  logic [DATA_W-1:0]    lat_wdata;
  logic [DATA_W-1:0]    rdata_q;

  logic [1:0]           grant;
  logic                 any_grant;
  logic                 fault;
  logic                 wait_done;
  logic                 in_resp;

  dmem_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1, req0}),
    .update (in_resp),
    .served (win_id),
    .grant  (grant)
  );

  assign any_grant = |grant;
  assign in_resp   = (state == ST_RESP);
  assign wait_done = (lat_cnt == LAT_CNT_W'(MEM_LAT - 1));

  // Decoded from the latched address only; live requester inputs are ignored after IDLE.
  assign fault = (|lat_addr[ADDR_W-1:RANGE_LSB]) ||
                 ((lat_addr[1:0] & ALIGN_MASK) != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_grant) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = (fault || lat_we) ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (wait_done) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt   <= '0;
      win_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          lat_cnt <= '0;
          if (any_grant) begin
            win_id    <= grant[1];
            lat_we    <= grant[1] ? we1    : we0;
            lat_addr  <= grant[1] ? addr1  : addr0;
            lat_wdata <= grant[1] ? wdata1 : wdata0;
            // Cleared so writes and faults return zero data.
            rdata_q   <= '0;
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (wait_done) begin
            rdata_q <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    if (state == ST_ISSUE && !fault) begin
      mem_read  = !lat_we;
      mem_write = lat_we;
      mem_addr  = lat_addr[WIDX_HI:WIDX_LO];
      mem_wdata = lat_we ? lat_wdata : '0;
    end
    if (in_resp) begin
      ack0 = !win_id;
      ack1 = win_id;
    end
  end

  assign err0   = ack0 && fault;
  assign err1   = ack1 && fault;
  assign rdata0 = ack0 ? rdata_q : '0;
  assign rdata1 = ack1 ? rdata_q : '0;

  assign stall0 = req0 && !ack0;
  assign stall1 = req1 && !ack1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected acks queued at drive time, checked at each ack.
module tb_dmem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LAT    = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              ack0, err0, stall0, ack1, err1, stall1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_read, mem_write;
  logic [7:0]        mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0), .stall0(stall0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1), .stall1(stall1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: read data appears the cycle after the strobe and is held.
  logic [DATA_W-1:0] mem [256];
  int cyc = 0;
  int strobes = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr];
    if (mem_read || mem_write) strobes <= strobes + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int               port;
    logic             err;
    logic [DATA_W-1:0] rdata;
    int               at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (ack0 || ack1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", {ack1, ack0}, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("ack_port", {ack1, ack0}, (mon_e.port == 1) ? 2'b10 : 2'b01);
        chk("ack_err", ack1 ? err1 : err0, mon_e.err);
        chk("ack_rdata", ack1 ? rdata1 : rdata0, mon_e.rdata);
        chk("ack_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 1) ? ack1 : ack0;
  endfunction

  function automatic logic stall_of(input int p);
    return (p == 1) ? stall1 : stall0;
  endfunction

  // One access from an idle arbiter; e = expected fault.
  task automatic access(input int p, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic e,
                        input logic [DATA_W-1:0] rd);
    int t0;
    int s0;
    bit got;
    logic [ADDR_W-1:0] av;
    av = a;
    @(negedge clk);
    t0 = cyc;
    s0 = strobes;
    drive(p, 1'b1, w, a, d);
    sbq.push_back('{p, e, rd, (w || e) ? t0 + 2 : t0 + 2 + LAT});
    @(negedge clk);
    if (!e) begin
      chk("strobe_rd", mem_read, !w);
      chk("strobe_wr", mem_write, w);
      chk("mem_addr", mem_addr, av[9:2]);
      if (w) chk("mem_wdata", mem_wdata, d);
    end else begin
      chk("no_strobe", {mem_read, mem_write}, 0);
    end
    chk("stall_issue", stall_of(p), 1);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (ack_of(p)) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("ack_seen", got, 1);
    chk("stall_at_ack", stall_of(p), 0);
    drive(p, 1'b0, 1'b0, '0, '0);
    chk("strobe_count", strobes - s0, e ? 0 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    int k0;
    int k1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0101_0101 * i;
    mem[4]  = 32'hDEAD_BEEF;
    mem[16] = 32'hA000_0000;
    mem[17] = 32'hA111_1111;
    mem[32] = 32'hB000_0000;
    mem[33] = 32'hB111_1111;

    repeat (3) @(negedge clk);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_err", {err1, err0}, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_strobe", {mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ack", {ack1, ack0}, 0);

    // Simultaneous requests held for four reads.
    @(negedge clk);
    t0 = cyc;
    drive(0, 1'b1, 1'b0, 16'h0040, '0);
    drive(1, 1'b1, 1'b0, 16'h0080, '0);
`ifdef DMEM_ARB_RR_EN
    sbq.push_back('{0, 1'b0, 32'hA000_0000, t0 + 2 + LAT});
    sbq.push_back('{1, 1'b0, 32'hB000_0000, t0 + 2 + LAT + (3 + LAT)});
    sbq.push_back('{0, 1'b0, 32'hA111_1111, t0 + 2 + LAT + 2 * (3 + LAT)});
    sbq.push_back('{1, 1'b0, 32'hB111_1111, t0 + 2 + LAT + 3 * (3 + LAT)});
`else
    sbq.push_back('{0, 1'b0, 32'hA000_0000, t0 + 2 + LAT});
    sbq.push_back('{0, 1'b0, 32'hA111_1111, t0 + 2 + LAT + (3 + LAT)});
    sbq.push_back('{1, 1'b0, 32'hB000_0000, t0 + 2 + LAT + 2 * (3 + LAT)});
    sbq.push_back('{1, 1'b0, 32'hB111_1111, t0 + 2 + LAT + 3 * (3 + LAT)});
`endif
    @(negedge clk);
    chk("tie_loser_stall", stall1, 1);
    n = 0; k0 = 0; k1 = 0;
    for (int i = 0; i < 80 && n < 4; i++) begin
      if (ack0) begin
        k0++; n++;
        if (k0 < 2) drive(0, 1'b1, 1'b0, 16'h0044, '0);
        else        drive(0, 1'b0, 1'b0, '0, '0);
      end
      if (ack1) begin
        k1++; n++;
        if (k1 < 2) drive(1, 1'b1, 1'b0, 16'h0084, '0);
        else        drive(1, 1'b0, 1'b0, '0, '0);
      end
      @(negedge clk);
    end
    chk("tie_acks", n, 4);

    // Single read, write then read-back, faults.
    access(0, 1'b0, 16'h0010, '0, 1'b0, 32'hDEAD_BEEF);
    access(1, 1'b1, 16'h03FC, 32'h1234_5678, 1'b0, '0);
    access(1, 1'b0, 16'h03FC, '0, 1'b0, 32'h1234_5678);
    access(0, 1'b0, 16'h0400, '0, 1'b1, '0);
    access(0, 1'b0, 16'h0002, '0, 1'b1, '0);
    access(1, 1'b1, 16'h8001, 32'hFFFF_FFFF, 1'b1, '0);
    access(0, 1'b0, 16'h03FC, '0, 1'b0, 32'h1234_5678);

    // Reset during WAIT drops the read without an ack.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0010, '0);
    @(negedge clk);
    chk("rst_test_issue", mem_read, 1);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_state", dut.state, 0);
    chk("rst_mid_strobe", {mem_read, mem_write}, 0);
    chk("rst_mid_ack", {ack1, ack0}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_quiet", {mem_read, mem_write, ack1, ack0}, 0);
    end
    access(1, 1'b0, 16'h0010, '0, 1'b0, 32'hDEAD_BEEF);

    repeat (5) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
